fsm_counter_sched: RTL and testbench

Shares one FSM_counter_v2-style counter instance (start/skip in, count_out/skip_to_five back) between N_REQ requesters. Each requester asks for a counting run to a target value, optionally with skip-to-five. The scheduler grants one requester at a time, drives the counter's start/skip, watches the count, and pulses done when the target is reached. It sits between client FSMs and the single counter datapath.

---
 rtl/fsm_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/fsm_counter_sched.sv | 182 ++++++++++++++++++
 tb/tb_fsm_counter_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_sched_pkg.sv
// Shared types and constants for the counter scheduler.
// Used by fsm_counter_sched and rr_arbiter (FSM_SCHED_PRIO_EN selects fixed priority).
package fsm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // Cycles the counter needs with start low before it is back at zero
  localparam int DRAIN_CYCLES = 2;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, or fixed lowest-index
// priority when FSM_SCHED_PRIO_EN is defined.
module rr_arbiter
  import fsm_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner
);

`ifdef FSM_SCHED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Descending scan so the lowest requesting index is written last
  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        winner    = '0;
        winner[k] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N_REQ)) pos = pos - (IDX_W + 1)'(N_REQ);
      if (!found && req[pos[IDX_W-1:0]]) begin
        winner[pos[IDX_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fsm_counter_sched.sv
// Shares one start/skip counter between N_REQ requesters, one run at a time.
// Arbitration mode is chosen in rr_arbiter via FSM_SCHED_PRIO_EN.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate among req, grant on next edge
// ST_RUN   | counter started for owner; watch for match, timeout or req drop
// ST_DRAIN | counter stopped, grant held DRAIN_CYCLES so the counter returns to 0
module fsm_counter_sched
  import fsm_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_skip,
  input  logic [N_REQ*CNT_W-1:0] req_target,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   busy,
  output logic                   cnt_start,
  output logic                   cnt_skip,
  input  logic [CNT_W-1:0]       cnt_count,
  input  logic                   cnt_skip_to_five
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = cnt_w(TIMEOUT);
  localparam int DRN_W = cnt_w(DRAIN_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             skip_q, skip_d;
  logic             skip_seen_q, skip_seen_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic [DRN_W-1:0] dcnt_q, dcnt_d;

  logic [N_REQ-1:0] winner;
  logic [IDX_W-1:0] win_idx;
  logic [CNT_W-1:0] win_target;
  logic             win_skip;
  logic             run_match;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      target_q    <= '0;
      skip_q      <= 1'b0;
      skip_seen_q <= 1'b0;
      tcnt_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      target_q    <= target_d;
      skip_q      <= skip_d;
      skip_seen_q <= skip_seen_d;
      tcnt_q      <= tcnt_d;
      dcnt_q      <= dcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = 1'b0;
    start_d     = 1'b0;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    target_d    = target_q;
    skip_d      = skip_q;
    skip_seen_d = skip_seen_q;
    tcnt_d      = tcnt_q;
    dcnt_d      = dcnt_q;

    win_idx    = '0;
    win_target = '0;
    win_skip   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_idx    = IDX_W'(i);
        win_target = req_target[i*CNT_W +: CNT_W];
        win_skip   = req_skip[i];
      end
    end

    // After a skip the count can land beyond a small target, so >= counts too
    run_match = (cnt_count == target_q) ||
                (skip_q && (skip_seen_q || cnt_skip_to_five) && (cnt_count >= target_q));

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d     = winner;
          owner_d     = win_idx;
          target_d    = win_target;
          skip_d      = win_skip;
          skip_seen_d = 1'b0;
          tcnt_d      = '0;
          dcnt_d      = '0;
          if (win_target == '0) begin
            done_d  = winner;
            state_d = ST_DRAIN;
          end else begin
            start_d = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        start_d     = 1'b1;
        tcnt_d      = tcnt_q + 1'b1;
        skip_seen_d = skip_seen_q | cnt_skip_to_five;
        if (!req[owner_q]) begin
          start_d = 1'b0;
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end else if (run_match) begin
          done_d  = grant_q;
          start_d = 1'b0;
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end else if (tcnt_q == TMO_LAST) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          start_d = 1'b0;
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DRN_LAST) begin
          grant_d  = '0;
          rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
          state_d  = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign cnt_start = start_q;
  // Dropped combinationally the cycle skip_to_five appears so the counter jumps only once
  assign cnt_skip  = (state_q == ST_RUN) && skip_q && !skip_seen_q && !cnt_skip_to_five;

endmodule

// File: tb/tb_fsm_counter_sched.sv
// Directed bench for fsm_counter_sched with a behavioural start/skip counter stub.
module tb_fsm_counter_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_skip;
  logic [N*W-1:0] req_target;
  logic [N-1:0]   grant, done;
  logic           err, busy, cnt_start, cnt_skip;
  logic [W-1:0]   cnt_count;
  logic           cnt_skip_to_five;
  logic           freeze;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_counter_sched #(.N_REQ(N), .CNT_W(W), .TIMEOUT(255)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_skip         (req_skip),
    .req_target       (req_target),
    .grant            (grant),
    .done             (done),
    .err              (err),
    .busy             (busy),
    .cnt_start        (cnt_start),
    .cnt_skip         (cnt_skip),
    .cnt_count        (cnt_count),
    .cnt_skip_to_five (cnt_skip_to_five)
  );

  // Counter stub: counts from 0 while start, jumps to 5 on skip, frozen at 0 when freeze
  always_ff @(posedge clk) begin
    if (!cnt_start || freeze) begin
      cnt_count        <= '0;
      cnt_skip_to_five <= 1'b0;
    end else if (cnt_skip) begin
      cnt_count        <= 8'd5;
      cnt_skip_to_five <= 1'b1;
    end else begin
      cnt_count <= cnt_count + 8'd1;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  skip;
    logic [31:0] tgts;
    logic        freeze;
    logic [3:0]  g;
    int          d;
    logic        e;
    int          sk;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] s, input logic [31:0] t,
                              input logic f, input logic [3:0] g, input int d, input logic e,
                              input int sk);
    vec_t v;
    v.req = r; v.skip = s; v.tgts = t; v.freeze = f; v.g = g; v.d = d; v.e = e; v.sk = sk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs_idle(input string name);
    chk(name, 32'({grant, done, err, busy, cnt_start, cnt_skip}), 32'd0);
  endtask

  task automatic run_entry(input int n, input vec_t v);
    int         didx, starts, skips, early_err;
    logic [3:0] dv;
    logic       ev;
    req = v.req; req_skip = v.skip; req_target = v.tgts; freeze = v.freeze;
    didx = -1; starts = 0; skips = 0; early_err = 0; dv = '0; ev = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d grant", n), 32'(grant), 32'(v.g));
    for (int c = 1; c <= 300; c++) begin
      if (done != '0) begin
        didx = c; dv = done; ev = err;
        break;
      end
      if (err) early_err++;
      if (cnt_start) starts++;
      if (cnt_skip) skips++;
      @(negedge clk);
    end
    chk($sformatf("v%0d done_cycle", n), 32'(didx), 32'(v.d));
    chk($sformatf("v%0d done_vec", n), 32'(dv), 32'(v.g));
    chk($sformatf("v%0d err", n), 32'(ev), 32'(v.e));
    chk($sformatf("v%0d err_early", n), 32'(early_err), 32'd0);
    chk($sformatf("v%0d start_cycles", n), 32'(starts), 32'(v.d - 1));
    chk($sformatf("v%0d skip_cycles", n), 32'(skips), 32'(v.sk));
    chk($sformatf("v%0d start_at_done", n), 32'(cnt_start), 32'd0);
    req = req & ~v.g;
    @(negedge clk);
    chk($sformatf("v%0d drain_grant", n), 32'({grant, done, cnt_start}), 32'({v.g, 4'b0, 1'b0}));
    @(negedge clk);
    chk($sformatf("v%0d idle_after_drain", n), 32'({grant, busy}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_skip = '0; req_target = '0; freeze = 1'b0;

    tbl[0]  = mk(4'b0001, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd10}, 0, 4'b0001, 12, 0, 0);
`ifdef FSM_SCHED_PRIO_EN
    tbl[1]  = mk(4'b0011, 4'b0000, {8'd0, 8'd0, 8'd9, 8'd7},  0, 4'b0001, 9, 0, 0);
`else
    tbl[1]  = mk(4'b0011, 4'b0000, {8'd0, 8'd0, 8'd9, 8'd7},  0, 4'b0010, 11, 0, 0);
`endif
    tbl[2]  = mk(4'b0011, 4'b0000, {8'd0, 8'd0, 8'd9, 8'd7},  0, 4'b0001, 9, 0, 0);
`ifdef FSM_SCHED_PRIO_EN
    tbl[3]  = mk(4'b0011, 4'b0000, {8'd0, 8'd0, 8'd9, 8'd7},  0, 4'b0001, 9, 0, 0);
`else
    tbl[3]  = mk(4'b0011, 4'b0000, {8'd0, 8'd0, 8'd9, 8'd7},  0, 4'b0010, 11, 0, 0);
`endif
    tbl[4]  = mk(4'b0100, 4'b0100, {8'd0, 8'd20, 8'd0, 8'd0}, 0, 4'b0100, 18, 0, 1);
    tbl[5]  = mk(4'b0100, 4'b0100, {8'd0, 8'd3, 8'd0, 8'd0},  0, 4'b0100, 3, 0, 1);
    tbl[6]  = mk(4'b0001, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd50}, 1, 4'b0001, 256, 1, 0);
    tbl[7]  = mk(4'b1000, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0},  0, 4'b1000, 1, 0, 0);
    tbl[8]  = mk(4'b1010, 4'b0000, {8'd1, 8'd0, 8'd2, 8'd0},  0, 4'b0010, 4, 0, 0);
`ifdef FSM_SCHED_PRIO_EN
    tbl[9]  = mk(4'b1010, 4'b0000, {8'd1, 8'd0, 8'd2, 8'd0},  0, 4'b0010, 4, 0, 0);
`else
    tbl[9]  = mk(4'b1010, 4'b0000, {8'd1, 8'd0, 8'd2, 8'd0},  0, 4'b1000, 3, 0, 0);
`endif
    tbl[10] = mk(4'b1010, 4'b0000, {8'd1, 8'd0, 8'd2, 8'd0},  0, 4'b0010, 4, 0, 0);
    tbl[11] = mk(4'b0001, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd254}, 0, 4'b0001, 256, 0, 0);
    tbl[12] = mk(4'b0001, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd255}, 0, 4'b0001, 256, 1, 0);

    repeat (10) @(negedge clk);
    chk_outputs_idle("reset_outputs");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_entry(i, tbl[i]);

    // Owner abandons its request mid-run: no done, counter stopped next cycle
    req = 4'b0001; req_skip = '0; req_target = {8'd0, 8'd0, 8'd0, 8'd30}; freeze = 1'b0;
    @(negedge clk);
    chk("abort grant", 32'(grant), 32'b0001);
    repeat (4) @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("abort drain1", 32'({grant, done, err, cnt_start}), 32'({4'b0001, 4'b0, 1'b0, 1'b0}));
    @(negedge clk);
    chk("abort drain2", 32'({grant, done, err, cnt_start}), 32'({4'b0001, 4'b0, 1'b0, 1'b0}));
    @(negedge clk);
    chk("abort idle", 32'({grant, busy}), 32'd0);

    // Reset mid-run returns everything, including the rr pointer, to reset values
    req = 4'b0010; req_target = {8'd0, 8'd0, 8'd30, 8'd0};
    @(negedge clk);
    chk("rstrun grant", 32'(grant), 32'b0010);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_idle("rstrun outputs");
    rst = 1'b0;
    req = 4'b0011; req_target = {8'd0, 8'd0, 8'd1, 8'd1};
    @(negedge clk);
    chk("rstrun ptr_grant", 32'(grant), 32'b0001);
    begin
      int didx;
      didx = -1;
      for (int c = 1; c <= 10; c++) begin
        if (done != '0) begin
          didx = c;
          break;
        end
        @(negedge clk);
      end
      chk("rstrun done_cycle", 32'(didx), 32'd3);
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("final idle", 32'({grant, busy}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
